// File: rtl/parity_pkg.sv
// Shared types and default sizing for the parity controller and its XOR generator.
package parity_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    EVAL    = 2'd2,
    SEND    = 2'd3
  } state_t;

endpackage

// File: rtl/parity_gen.sv
// Combinational parity: XOR of every data bit, inverted when odd parity is requested.
module parity_gen
  import parity_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] data,
  input  logic             odd_mode,
  output logic             parity
);

  assign parity = (^data) ^ odd_mode;

endmodule

// File: rtl/parity_ctrl.sv
// Parity generate/check controller: accepts one byte, evaluates parity, and holds the
// result until the consumer takes it, keeping frame and mismatch counters.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | in_ready=1, waiting for in_valid; byte and mode bits captured
//   CAPTURE | registered byte presented to parity_gen
//   EVAL    | parity and error flag registered into the output fields
//   SEND    | out_valid=1, outputs frozen until out_ready; counters update
module parity_ctrl
  import parity_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_chk,
  input  logic             chk_en,
  input  logic             odd_mode,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_parity,
  output logic             out_err,
  input  logic             out_ready,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] frame_count
);

  state_t           state;
  logic [WIDTH-1:0] data_q;
  logic             chk_q;
  logic             chk_en_q;
  logic             odd_q;
  logic             par;

  parity_gen #(.WIDTH(WIDTH)) u_parity_gen (
    .data     (data_q),
    .odd_mode (odd_q),
    .parity   (par)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_parity  <= 1'b0;
      out_err     <= 1'b0;
      err_count   <= '0;
      frame_count <= '0;
      data_q      <= '0;
      chk_q       <= 1'b0;
      chk_en_q    <= 1'b0;
      odd_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // mode bits are frozen here so later changes cannot touch the in-flight byte
          if (in_valid && in_ready) begin
            data_q   <= in_data;
            chk_q    <= in_chk;
            chk_en_q <= chk_en;
            odd_q    <= odd_mode;
            in_ready <= 1'b0;
            state    <= CAPTURE;
          end
        end
        CAPTURE: begin
          state <= EVAL;
        end
        EVAL: begin
          out_data   <= data_q;
          out_parity <= par;
          out_err    <= chk_en_q && (par != chk_q);
          out_valid  <= 1'b1;
          state      <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            in_ready    <= 1'b1;
            frame_count <= frame_count + 1'b1;
            if (out_err && (err_count != {CNT_W{1'b1}}))
              err_count <= err_count + 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_ctrl.sv
// Directed bench for parity_ctrl: generate/check modes, stall, reset abort and counter limits.
module tb_parity_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_chk;
  logic       chk_en;
  logic       odd_mode;
  logic       out_ready;

  logic       in_ready, out_valid, out_parity, out_err;
  logic [7:0] out_data, err_count, frame_count;

  logic       in_ready_2, out_valid_2, out_parity_2, out_err_2;
  logic [7:0] out_data_2;
  logic [1:0] err_count_2, frame_count_2;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_fc   = 0;
  int exp_ec   = 0;

  parity_ctrl #(.WIDTH(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_chk(in_chk),
    .chk_en(chk_en), .odd_mode(odd_mode), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_parity(out_parity), .out_err(out_err), .out_ready(out_ready),
    .err_count(err_count), .frame_count(frame_count)
  );

  parity_ctrl #(.WIDTH(8), .CNT_W(2)) u_dut_2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_chk(in_chk),
    .chk_en(chk_en), .odd_mode(odd_mode), .in_ready(in_ready_2), .out_valid(out_valid_2),
    .out_data(out_data_2), .out_parity(out_parity_2), .out_err(out_err_2), .out_ready(out_ready),
    .err_count(err_count_2), .frame_count(frame_count_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transfer; mode inputs are scrambled right after accept to prove they were latched.
  task automatic xfer(input logic [7:0] d, input logic ce, input logic odd, input logic ic,
                      input logic ep, input logic ee, input logic rdy_early);
    in_data   = d;
    chk_en    = ce;
    odd_mode  = odd;
    in_chk    = ic;
    in_valid  = 1'b1;
    out_ready = rdy_early;
    check("in_ready_idle", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk_en   = ~ce;
    odd_mode = ~odd;
    in_chk   = ~ic;
    in_data  = ~d;
    check("valid_capture", out_valid, 0);
    check("in_ready_busy", in_ready, 0);
    tick();
    check("valid_eval", out_valid, 0);
    tick();
    check("valid_send", out_valid, 1);
    check("out_data", out_data, d);
    check("out_parity", out_parity, ep);
    check("out_err", out_err, ee);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_fc = (exp_fc + 1) % 256;
    if (ee && exp_ec < 255) exp_ec++;
    check("valid_after", out_valid, 0);
    check("in_ready_after", in_ready, 1);
    check("data_hold", out_data, d);
    check("frame_count", frame_count, exp_fc);
    check("err_count", err_count, exp_ec);
  endtask

  logic [7:0] gen_bytes [4] = '{8'hFD, 8'h1C, 8'h44, 8'hFF};
  logic       even_par  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [1:0] fc_seq    [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [1:0] ec_seq    [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_chk = 1'b0;
    chk_en = 1'b0; odd_mode = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_parity", out_parity, 0);
    check("rst_out_err", out_err, 0);
    check("rst_frame", frame_count, 0);
    check("rst_err", err_count, 0);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);

    // generate mode, even then odd; second byte keeps out_ready high from the start
    for (int i = 0; i < 4; i++)
      xfer(gen_bytes[i], 1'b0, 1'b0, 1'b1, even_par[i], 1'b0, (i == 1));
    check("frame_after_even", frame_count, 4);
    for (int i = 0; i < 4; i++)
      xfer(gen_bytes[i], 1'b0, 1'b1, 1'b0, ~even_par[i], 1'b0, 1'b0);

    // check mode, even parity
    xfer(8'hFD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("err_after_fd", err_count, 1);
    xfer(8'h44, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("err_after_44", err_count, 1);

    // stall in SEND for 10 cycles with stray in_valid pulses
    in_data = 8'h1C; chk_en = 1'b1; odd_mode = 1'b0; in_chk = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data  = 8'(i * 17);
      tick();
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, 8'h1C);
      check("stall_parity", out_parity, 1);
      check("stall_err", out_err, 1);
      check("stall_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_fc++;
    exp_ec++;
    check("stall_frame", frame_count, exp_fc);
    check("stall_errcnt", err_count, exp_ec);
    check("stall_release", out_valid, 0);

    // reset during EVAL
    in_data = 8'hAA; chk_en = 1'b0; odd_mode = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_fc = 0; exp_ec = 0;
    check("rst_eval_valid", out_valid, 0);
    check("rst_eval_ready", in_ready, 1);
    check("rst_eval_frame", frame_count, 0);
    check("rst_eval_err", err_count, 0);
    check("rst_eval_data", out_data, 0);
    tick(); tick(); tick();
    check("rst_eval_no_out", out_valid, 0);
    check("rst_eval_data2", out_data, 0);

    // reset during SEND, with out_ready asserted on the same edge
    in_data = 8'h55; chk_en = 1'b1; in_chk = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("pre_rst_send", out_valid, 1);
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    check("rst_send_valid", out_valid, 0);
    check("rst_send_ready", in_ready, 1);
    check("rst_send_frame", frame_count, 0);
    check("rst_send_err", err_count, 0);
    check("rst_send_data", out_data, 0);

    // narrow counters: wrap and saturation
    for (int i = 0; i < 5; i++) begin
      xfer(8'hFD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      check("w2_frame", frame_count_2, fc_seq[i]);
      check("w2_err", err_count_2, ec_seq[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

endmodule
